uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
Controller between the UART byte receiver and the instruction memory of the single-cycle CPU. It turns the host byte stream into a program load: a 16-bit instruction count, then that many 16-bit instructions, each sent LSB first. It writes instructions to consecutive imem addresses from 0, holds the CPU in stall while loading, and drives the "paused" LED. Sits in the SingleCPU top level, between uart_rx and the imem write port.

Parameters:
ADDR_W, 8, imem address width; capacity is 2^ADDR_W words (256)
DATA_W, 16, instruction width; fixed at 2 bytes per word
TIMEOUT_CYC, 1000000, max idle CLK cycles between bytes once a load has started (20 ms at 50 MHz)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous reset, active-high
load_req  in  1  single-cycle pulse (synchronised, debounced); re-arms loader
rx_data  in  8  byte from uart_rx
rx_valid  in  1  one-cycle strobe, rx_data valid
imem_we  out  1  imem write enable, one cycle per instruction
imem_addr  out  ADDR_W  imem write address
imem_wdata  out  DATA_W  imem write data
cpu_hold  out  1  1 = CPU stalled, PC held at 0
loading  out  1  LED drive; 1 while waiting for or receiving a program
load_done  out  1  level; 1 after a complete, error-free load
load_err  out  1  level; 1 after count overflow or timeout
word_count  out  16  count received for the current load

Behaviour:
- States: CNT_LO, CNT_HI, INS_LO, INS_HI, DONE, ERR.
- Reset values: state=CNT_LO, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, loading=1, load_done=0, load_err=0, word_count=0, internal index=0, timer=0.
- CNT_LO: on rx_valid, latch the byte into word_count[7:0] -> CNT_HI. No timeout applies here; the loader waits indefinitely for the host.
- CNT_HI: on rx_valid, latch word_count[15:8], then check the count:
  - count==0 -> DONE.
  - count>2^ADDR_W -> ERR.
  - otherwise -> INS_LO.
- INS_LO: on rx_valid, store the LSB -> INS_HI.
- INS_HI: on rx_valid, form the word {byte, stored LSB}.
  - Next cycle (1-cycle registered latency): imem_we=1, imem_addr=index, imem_wdata=word.
  - index increments after the write.
  - If index+1==word_count -> DONE, else -> INS_LO.
- The last write is issued in the same cycle as the DONE entry. imem_we never asserts outside that single write cycle.
- DONE: load_done=1, loading=0, cpu_hold=0. rx_valid is ignored.
- ERR: load_err=1, loading=0, cpu_hold=1. rx_valid is ignored.
- loading=1 and cpu_hold=1 in CNT_LO, CNT_HI, INS_LO and INS_HI.
- Timeout:
  - Timer clears on every rx_valid and counts in CNT_HI, INS_LO and INS_HI.
  - Reaching TIMEOUT_CYC -> ERR. This covers a half-received word and a stalled host.
- load_req, in any state:
  - Next cycle: state=CNT_LO, index=0, word_count=0, timer=0, load_done=0, load_err=0, cpu_hold=1, loading=1.
  - load_req together with rx_valid: load_req wins and the byte is discarded.
  - load_req together with a pending write: the write is cancelled.
- RESET asserted mid-load: immediate return to reset values. Already-written imem contents are not cleared.
- Index arithmetic is ADDR_W+1 bits wide, so count==2^ADDR_W loads the full memory without wrap. imem_addr is the low ADDR_W bits.

Decomposition:
- Package cpu_loader_pkg holds:
  - state encoding localparams (3 bits);
  - BYTES_PER_WORD=2;
  - default TIMEOUT_CYC at 50 MHz.
- One sub-module, loader_byte_pair: assembles an LSB/MSB byte pair into a 16-bit word with a word_valid strobe, and exposes a clear input driven by load_req and timeout. The FSM, timer and write port stay in uart_prog_loader.

Test Plan:
1. Reset, then bytes 03,00, then words 0x1234, 0xABCD, 0x0F0F (LSB first) -> three imem_we pulses at addr 0,1,2 with matching data; then load_done=1, loading=0, cpu_hold=0, word_count=3.
2. Reset, bytes 00,00 -> DONE with no imem_we; cpu_hold=0 the cycle after the second byte.
3. Bytes 01,01 (count 257, ADDR_W=8) -> ERR, load_err=1, cpu_hold=1, no writes. Then a load_req pulse -> CNT_LO, loading=1. Then a valid 1-word load succeeds at addr 0.
4. Count 2, word 0x5555, then only byte 0x77 followed by TIMEOUT_CYC idle cycles (TIMEOUT_CYC=100 for sim) -> exactly one write (addr 0), then ERR.
5. load_req in the same cycle as the rx_valid of an instruction MSB -> no imem_we; state CNT_LO; the next two bytes are taken as the new count.
6. RESET asserted during INS_HI, then released, then a full 2-word load -> writes at addr 0,1 only; outputs equal reset values immediately on assertion.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared constants for the UART program loader: state encoding, word geometry
// and the default inter-byte timeout.
package cpu_loader_pkg;

    localparam logic [2:0] ST_CNT_LO = 3'd0;
    localparam logic [2:0] ST_CNT_HI = 3'd1;
    localparam logic [2:0] ST_INS_LO = 3'd2;
    localparam logic [2:0] ST_INS_HI = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam int BYTES_PER_WORD = 2;

    // 20 ms of silence at 50 MHz
    localparam int TIMEOUT_CYC_DEFAULT = 1_000_000;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-stream / imem-write bundle of the program loader. slave = the loader,
// master = the host side (uart_rx, button logic, imem, LEDs).
interface uart_prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              loading;
    logic              load_done;
    logic              load_err;
    logic [15:0]       word_count;

    modport slave (
        input  load_req, rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, cpu_hold, loading,
               load_done, load_err, word_count
    );

    modport master (
        output load_req, rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, loading,
               load_done, load_err, word_count
    );
endinterface

// File: rtl/loader_byte_pair.sv
// Assembles an LSB/MSB byte pair into one instruction word; word_valid pulses
// for the single cycle after the MSB arrives and doubles as the imem write strobe.
module loader_byte_pair
    import cpu_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          lsb_en,
    input  logic                          msb_en,
    input  logic [7:0]                    rx_byte,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_valid
);

    logic [7:0] lsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            lsb        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= msb_en;
            if (lsb_en)
                lsb <= rx_byte;
            if (msb_en)
                word <= {rx_byte, lsb};
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Host program loader: 16-bit count then count instructions (LSB first) written
// to imem from address 0 while the CPU is held in stall.
//
// state  | meaning
// CNT_LO | waiting for count LSB (no timeout)
// CNT_HI | waiting for count MSB
// INS_LO | waiting for instruction LSB
// INS_HI | waiting for instruction MSB
// DONE   | program loaded, CPU released
// ERR    | count overflow or timeout, CPU held
module uart_prog_loader
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)
(
    input logic                CLK,
    input logic                RESET,
    uart_prog_loader_if.slave  bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    logic [2:0]        state;
    logic [ADDR_W:0]   index;
    logic [TMR_W-1:0]  timer;
    logic [15:0]       word_count;
    logic [15:0]       count_full;
    logic [15:0]       idx_next;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              timing;
    logic              timeout;
    logic              lsb_en;
    logic              msb_en;

    assign timing  = (state == ST_CNT_HI) || (state == ST_INS_LO) || (state == ST_INS_HI);
    assign timeout = timing && !bus.rx_valid && (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign lsb_en  = (state == ST_INS_LO) && bus.rx_valid && !bus.load_req;
    assign msb_en  = (state == ST_INS_HI) && bus.rx_valid && !bus.load_req;

    assign count_full = {bus.rx_data, word_count[7:0]};
    assign idx_next   = 16'(index) + 16'd1;

    loader_byte_pair u_pair (
        .clk        (CLK),
        .rst        (RESET),
        .clear      (bus.load_req | timeout),
        .lsb_en     (lsb_en),
        .msb_en     (msb_en),
        .rx_byte    (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_CNT_LO;
            index      <= '0;
            timer      <= '0;
            word_count <= '0;
        end else if (bus.load_req) begin
            state      <= ST_CNT_LO;
            index      <= '0;
            timer      <= '0;
            word_count <= '0;
        end else begin
            if (bus.rx_valid || !timing)
                timer <= '0;
            else
                timer <= timer + TMR_W'(1);
            // Index advances at the end of the write cycle, so imem_addr shows
            // the address actually being written.
            if (word_valid)
                index <= index + (ADDR_W+1)'(1);
            case (state)
                ST_CNT_LO: if (bus.rx_valid) begin
                    word_count[7:0] <= bus.rx_data;
                    state           <= ST_CNT_HI;
                end
                ST_CNT_HI: if (bus.rx_valid) begin
                    word_count[15:8] <= bus.rx_data;
                    if (count_full == 16'd0)
                        state <= ST_DONE;
                    else if ({1'b0, count_full} > CAPACITY)
                        state <= ST_ERR;
                    else
                        state <= ST_INS_LO;
                end else if (timeout) begin
                    state <= ST_ERR;
                end
                ST_INS_LO: if (bus.rx_valid)
                    state <= ST_INS_HI;
                else if (timeout)
                    state <= ST_ERR;
                ST_INS_HI: if (bus.rx_valid)
                    state <= (idx_next == word_count) ? ST_DONE : ST_INS_LO;
                else if (timeout)
                    state <= ST_ERR;
                ST_DONE: state <= ST_DONE;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_CNT_LO;
            endcase
        end
    end

    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = index[ADDR_W-1:0];
    assign bus.imem_wdata = word;
    assign bus.word_count = word_count;
    assign bus.loading    = timing || (state == ST_CNT_LO);
    assign bus.cpu_hold   = (state != ST_DONE);
    assign bus.load_done  = (state == ST_DONE);
    assign bus.load_err   = (state == ST_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a shortened timeout; imem writes
// are recorded on the falling edge and checked against hand-computed values.
module tb_uart_prog_loader;

    localparam int TMO = 100;

    logic CLK = 1'b0;
    logic RESET;
    int   total  = 0;
    int   passed = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    uart_prog_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    uart_prog_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(TMO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLK);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_we"},    32'(bus.imem_we),    32'd0);
        chk({tag, "_addr"},  32'(bus.imem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(bus.imem_wdata), 32'd0);
        chk({tag, "_hold"},  32'(bus.cpu_hold),   32'd1);
        chk({tag, "_ldg"},   32'(bus.loading),    32'd1);
        chk({tag, "_done"},  32'(bus.load_done),  32'd0);
        chk({tag, "_err"},   32'(bus.load_err),   32'd0);
        chk({tag, "_cnt"},   32'(bus.word_count), 32'd0);
    endtask

    initial begin
        RESET        = 1'b1;
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        chk_reset_values("rst");
        RESET = 1'b0;

        // 1: three-word load
        send_byte(8'h03); send_byte(8'h00);
        chk("t1_cnt", 32'(bus.word_count), 32'd3);
        chk("t1_ldg", 32'(bus.loading), 32'd1);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h0F);
        chk("t1_pre_done", 32'(bus.load_done), 32'd0);
        send_byte(8'h0F);
        chk("t1_last_we", 32'(bus.imem_we), 32'd1);
        chk("t1_done_same_cyc", 32'(bus.load_done), 32'd1);
        idle(2);
        chk("t1_nwr", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t1_a0", 32'(wr_addr[0]), 32'd0); chk("t1_d0", 32'(wr_data[0]), 32'h1234);
            chk("t1_a1", 32'(wr_addr[1]), 32'd1); chk("t1_d1", 32'(wr_data[1]), 32'hABCD);
            chk("t1_a2", 32'(wr_addr[2]), 32'd2); chk("t1_d2", 32'(wr_data[2]), 32'h0F0F);
        end
        chk("t1_done", 32'(bus.load_done), 32'd1);
        chk("t1_ldg_off", 32'(bus.loading), 32'd0);
        chk("t1_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t1_we_idle", 32'(bus.imem_we), 32'd0);
        send_byte(8'h55);
        chk("t1_ignore_rx", 32'(bus.word_count), 32'd3);

        // 2: zero-length program
        pulse_reset();
        send_byte(8'h00); send_byte(8'h00);
        chk("t2_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t2_done", 32'(bus.load_done), 32'd1);
        idle(2);
        chk("t2_nwr", wr_addr.size(), 32'd0);

        // 3: count 257 overflows, then re-arm and load one word
        pulse_reset();
        send_byte(8'h01); send_byte(8'h01);
        chk("t3_err", 32'(bus.load_err), 32'd1);
        chk("t3_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t3_ldg", 32'(bus.loading), 32'd0);
        chk("t3_cnt", 32'(bus.word_count), 32'h0101);
        send_byte(8'h00);
        chk("t3_err_sticky", 32'(bus.load_err), 32'd1);
        @(negedge CLK); bus.load_req = 1'b1;
        @(negedge CLK); bus.load_req = 1'b0;
        chk("t3_rearm_ldg", 32'(bus.loading), 32'd1);
        chk("t3_rearm_err", 32'(bus.load_err), 32'd0);
        chk("t3_rearm_cnt", 32'(bus.word_count), 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        idle(2);
        chk("t3_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t3_a0", 32'(wr_addr[0]), 32'd0);
            chk("t3_d0", 32'(wr_data[0]), 32'hBEEF);
        end
        chk("t3_done", 32'(bus.load_done), 32'd1);

        // 4: half-received second word times out
        pulse_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h55);
        send_byte(8'h77);
        idle(TMO - 5);
        chk("t4_not_yet", 32'(bus.load_err), 32'd0);
        idle(10);
        chk("t4_err", 32'(bus.load_err), 32'd1);
        chk("t4_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t4_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t4_a0", 32'(wr_addr[0]), 32'd0);
            chk("t4_d0", 32'(wr_data[0]), 32'h5555);
        end

        // 5: load_req collides with an instruction MSB
        pulse_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33);
        @(negedge CLK);
        bus.rx_data = 8'h44; bus.rx_valid = 1'b1; bus.load_req = 1'b1;
        @(negedge CLK);
        bus.rx_valid = 1'b0; bus.load_req = 1'b0;
        chk("t5_no_we", 32'(bus.imem_we), 32'd0);
        chk("t5_cnt0", 32'(bus.word_count), 32'd0);
        chk("t5_ldg", 32'(bus.loading), 32'd1);
        idle(2);
        chk("t5_nwr_cancel", wr_addr.size(), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        chk("t5_newcnt", 32'(bus.word_count), 32'd1);
        chk("t5_not_done", 32'(bus.load_done), 32'd0);
        send_byte(8'hAA); send_byte(8'hBB);
        idle(2);
        chk("t5_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t5_a1", 32'(wr_addr[1]), 32'd0);
            chk("t5_d1", 32'(wr_data[1]), 32'hBBAA);
        end
        chk("t5_done", 32'(bus.load_done), 32'd1);

        // 6: asynchronous reset during INS_HI, then a fresh two-word load
        pulse_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1 chk_reset_values("t6_async");
        @(negedge CLK);
        RESET = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hA0);
        send_byte(8'h02); send_byte(8'hB0);
        idle(2);
        chk("t6_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t6_a0", 32'(wr_addr[0]), 32'd0); chk("t6_d0", 32'(wr_data[0]), 32'hA001);
            chk("t6_a1", 32'(wr_addr[1]), 32'd1); chk("t6_d1", 32'(wr_data[1]), 32'hB002);
        end
        chk("t6_done", 32'(bus.load_done), 32'd1);
        chk("t6_cnt", 32'(bus.word_count), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
